unidade_controle_rodadas: RTL
=============================

Name: unidade_controle_rodadas

Overview:
- Moore-style control unit for the memory-game datapath, next generation of the single-sequence controller.
- Adds two play modes, selected per game:
  - modo=0: one pass over the full sequence.
  - modo=1: progressive rounds. Round k requires plays 0..k.
- Adds a parametrised per-play timeout with an internal timer and a distinct timeout end state.
- Drives the external play counter (E), round counter (L) and the play register of the datapath.

Parameters:
TIMEOUT_CICLOS, 5000, cycles allowed in espera before timeout; legal range >= 2.
TW, $clog2(TIMEOUT_CICLOS), timer width; derived, not overridden.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state inicial
iniciar  input  1  start / restart request (level, sampled each cycle)
jogada  input  1  one-cycle pulse: player pressed a button
igual  input  1  registered play equals stored sequence entry
fimE  input  1  play counter equals current round limit (modo=1) or last address (modo=0)
fimL  input  1  round counter at last round
modo  input  1  0 = single pass, 1 = progressive rounds; sampled in preparacao
zeraE  output  1  clear play counter
contaE  output  1  increment play counter
zeraL  output  1  clear round counter
contaL  output  1  increment round counter
zeraR  output  1  clear play register
registraR  output  1  load play register
pronto  output  1  game finished (any end state)
acertou  output  1  game won
errou  output  1  game lost (wrong play or timeout)
timeout  output  1  game lost by timeout
db_estado  output  4  current state code for 7-segment debug

Behaviour:
- State codes:
  - inicial=0, espera=1, inicio_rodada=2, preparacao=3, registra=4, comparacao=5
  - proximo=6, proxima_rodada=7, estouro=C, vitoria=D, derrota=E
  - unused codes -> inicial next cycle; db_estado=F if ever observed.
- Transitions (registered, one per clock):
  - inicial: iniciar -> preparacao; else stay.
  - preparacao -> inicio_rodada; modo latched into modo_r this cycle.
  - inicio_rodada -> espera.
  - espera:
    - jogada -> registra.
    - else timer == TIMEOUT_CICLOS-1 -> estouro.
    - else stay.
    - jogada wins over simultaneous expiry.
  - registra -> comparacao.
  - comparacao:
    - ~igual -> derrota.
    - igual & fimE & (~modo_r | fimL) -> vitoria.
    - igual & fimE & modo_r & ~fimL -> proxima_rodada.
    - else proximo.
  - proximo -> espera.
  - proxima_rodada -> inicio_rodada.
  - derrota / vitoria / estouro: iniciar -> preparacao (direct new game); else stay.
- Outputs (pure decode of state; no input feeds an output):
  - zeraE: inicial, preparacao, inicio_rodada.
  - zeraL, zeraR: inicial, preparacao.
  - registraR: registra.
  - contaE: proximo.
  - contaL: proxima_rodada; never asserted when modo_r=0.
  - pronto: estouro, vitoria, derrota.
  - acertou: vitoria.
  - errou: derrota, estouro.
  - timeout: estouro.
- Reset:
  - State inicial and modo_r=0.
  - Timer cleared.
  - Outputs: zeraE=zeraL=zeraR=1, all others 0, db_estado=0.
  - Reset mid-game aborts immediately; no end state is reported.
- Timer (TW bits):
  - Cleared in every state except espera.
  - Increments by 1 each cycle in espera.
  - Timeout therefore fires after exactly TIMEOUT_CICLOS consecutive espera cycles without jogada.
  - The timer restarts on each re-entry to espera.
  - The timer never wraps, because it leaves espera at TIMEOUT_CICLOS-1.
- Changing modo outside preparacao has no effect until the next game.
- A jogada pulse outside espera is ignored.
- iniciar held high in an end state gives exactly one preparacao pass and then proceeds normally; a held iniciar does not re-trigger restarts.

Decomposition:
- Shared package/include holds:
  - the 4-bit state encodings above;
  - the MODO_SIMPLES=0 / MODO_PROGRESSIVO=1 constants.
- One sub-module: contador_timeout
  - parametrised TW/limit;
  - ports clock, reset, zera, conta, fim;
  - fim is combinational (count == limit-1).
- The FSM instantiates it with zera = ~espera and conta = espera.

Test Plan:
- Single-pass win:
  - Stimulus: TIMEOUT_CICLOS=8, modo=0, iniciar; 4 jogadas with igual=1; fimE=1 on the 4th.
  - Required: states 0,3,2,1,4,5,6,1,... ending D; contaE pulses 3 times; acertou=pronto=1; contaL never 1.
- Progressive win:
  - Stimulus: modo=1, 3 rounds; fimE on the last play of each round; fimL in round 3.
  - Required: proxima_rodada (7) visited twice; contaL pulses 2 times; zeraE in each inicio_rodada; final state D.
- Wrong play:
  - Stimulus: igual=0 at the 2nd comparacao.
  - Required: next state E; errou=pronto=1; acertou=timeout=0; iniciar -> state 3 next cycle.
- Timeout:
  - Stimulus: enter espera, no jogada for 8 cycles.
  - Required: state C on cycle 9; timeout=errou=pronto=1.
  - Repeat with jogada in cycle 8 -> registra, no timeout.
- Mode latch and async reset:
  - Stimulus: toggle modo mid-game -> no change in path.
  - Stimulus: assert reset between clock edges in comparacao -> db_estado=0 and zeraE=zeraL=zeraR=1 before the next edge.

Source files
------------

// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the round-based memory-game control unit:
// state encodings (also shown on the debug display) and play-mode constants.
package unidade_controle_rodadas_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        ESPERA         = 4'h1,
        INICIO_RODADA  = 4'h2,
        PREPARACAO     = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        ESTOURO        = 4'hC,
        VITORIA        = 4'hD,
        DERROTA        = 4'hE
    } estado_t;

    localparam logic MODO_SIMPLES     = 1'b0;
    localparam logic MODO_PROGRESSIVO = 1'b1;

    // Shown on the debug display if the state register ever holds an unused code
    localparam logic [3:0] DB_INVALIDO = 4'hF;

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-play timeout counter: cleared with zera, counts with conta, and flags
// fim combinationally when the count reaches LIMITE-1.
module contador_timeout #(
    parameter int LIMITE = 5000,
    parameter int TW     = $clog2(LIMITE)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [TW-1:0] contagem_q;
    logic [TW-1:0] contagem_d;

    // Clear has priority over counting; otherwise hold the current value
    always_comb begin
        contagem_d = contagem_q;
        if (zera) begin
            contagem_d = '0;
        end else if (conta) begin
            contagem_d = contagem_q + TW'(1);
        end
    end

    // Count register, cleared asynchronously by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign fim = (contagem_q == TW'(LIMITE - 1));

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the memory game: single-pass or progressive-round
// play, with a per-play timeout measured while waiting for a button press.
module unidade_controle_rodadas
    import unidade_controle_rodadas_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    input  logic       modo,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int TW = $clog2(TIMEOUT_CICLOS);

    estado_t estado_q;
    estado_t estado_d;
    logic    modo_q;
    logic    modo_d;
    logic    emEspera;
    logic    fimTimer;

    assign emEspera = (estado_q == ESPERA);

    // Timer only runs while waiting for a play; any other state restarts it
    contador_timeout #(
        .LIMITE (TIMEOUT_CICLOS),
        .TW     (TW)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (~emEspera),
        .conta (emEspera),
        .fim   (fimTimer)
    );

    // Play mode is captured once per game, during preparacao
    always_comb begin
        modo_d = modo_q;
        if (estado_q == PREPARACAO) begin
            modo_d = modo;
        end
    end

    // State and latched mode registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
            modo_q   <= MODO_SIMPLES;
        end else begin
            estado_q <= estado_d;
            modo_q   <= modo_d;
        end
    end

    // Next-state logic; a play beats a simultaneous timer expiry
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = ESPERA;
            ESPERA: begin
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (fimTimer) begin
                    estado_d = ESTOURO;
                end else begin
                    estado_d = ESPERA;
                end
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    estado_d = DERROTA;
                end else if (fimE && (modo_q == MODO_SIMPLES || fimL)) begin
                    estado_d = VITORIA;
                end else if (fimE) begin
                    estado_d = PROXIMA_RODADA;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:        estado_d = ESPERA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            ESTOURO:        estado_d = iniciar ? PREPARACAO : ESTOURO;
            VITORIA:        estado_d = iniciar ? PREPARACAO : VITORIA;
            DERROTA:        estado_d = iniciar ? PREPARACAO : DERROTA;
            default:        estado_d = INICIAL;
        endcase
    end

    // Output decode depends on the current state only
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = DB_INVALIDO;
        case (estado_q)
            INICIAL: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                db_estado = 4'h0;
            end
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                db_estado = 4'h3;
            end
            INICIO_RODADA: begin
                zeraE = 1'b1;
                db_estado = 4'h2;
            end
            ESPERA: begin
                db_estado = 4'h1;
            end
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = 4'h4;
            end
            COMPARACAO: begin
                db_estado = 4'h5;
            end
            PROXIMO: begin
                contaE = 1'b1;
                db_estado = 4'h6;
            end
            PROXIMA_RODADA: begin
                contaL = 1'b1;
                db_estado = 4'h7;
            end
            ESTOURO: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
                db_estado = 4'hC;
            end
            VITORIA: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                db_estado = 4'hD;
            end
            DERROTA: begin
                pronto = 1'b1;
                errou  = 1'b1;
                db_estado = 4'hE;
            end
            default: begin
                db_estado = DB_INVALIDO;
            end
        endcase
    end

endmodule
